// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/redirect requests from the pipeline and the per-stage controls returned to it
interface pipe_ctrl_if;
  logic        de_stall, jump_req, mul_start, ifu_bus_wait, lsu_bus_wait;
  logic [31:0] jump_addr, jump_addr_o;
  logic [3:0]  stall;
  logic        flush_de, bubble_alu, bubble_lsu, jump_en, mul_done, discard_fetch, busy;
  modport master (
    output de_stall, jump_req, jump_addr, mul_start, ifu_bus_wait, lsu_bus_wait,
    input  stall, flush_de, bubble_alu, bubble_lsu, jump_en, jump_addr_o, mul_done, discard_fetch, busy
  );
  modport slave (
    input  de_stall, jump_req, jump_addr, mul_start, ifu_bus_wait, lsu_bus_wait,
    output stall, flush_de, bubble_alu, bubble_lsu, jump_en, jump_addr_o, mul_done, discard_fetch, busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencer arbitrating stalls, redirects, multiply latency and stale-fetch discard
module pipe_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);
  typedef enum logic {RUN, MUL} state_t;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 2);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             fetch_kill, fetch_kill_nx, discard;
  logic [3:0]       stall;
  logic             flush_de, bubble_alu, bubble_lsu, jump_en, mul_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      fetch_kill <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      fetch_kill <= fetch_kill_nx;
    end
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    stall      = 4'b0000;
    flush_de   = 1'b0;
    bubble_alu = 1'b0;
    bubble_lsu = 1'b0;
    jump_en    = 1'b0;
    mul_done   = 1'b0;
    if (state == MUL) begin
      if (bus.lsu_bus_wait) stall = 4'b1111;
      else if (cnt != '0) begin
        stall      = 4'b0111;
        bubble_lsu = 1'b1;
        cnt_nx     = cnt - 1'b1;
      end else begin
        mul_done = 1'b1;
        state_nx = RUN;
      end
    end else if (bus.lsu_bus_wait) stall = 4'b1111;
    else if (bus.jump_req) begin
      jump_en    = 1'b1;
      flush_de   = 1'b1;
      bubble_alu = 1'b1;
    end else if (bus.mul_start) begin
      stall      = 4'b0111;
      bubble_lsu = 1'b1;
      cnt_nx     = CNT_INIT;
      state_nx   = MUL;
    end else if (bus.de_stall) begin
      stall      = 4'b0011;
      bubble_alu = 1'b1;
    end else if (bus.ifu_bus_wait) begin
      stall    = 4'b0001;
      flush_de = 1'b1;
    end
  end
  // Only one fetch can be outstanding, so a second redirect simply keeps the kill armed
  assign discard       = fetch_kill & ~bus.ifu_bus_wait;
  assign fetch_kill_nx = (jump_en & bus.ifu_bus_wait) | (fetch_kill & ~discard);
  assign bus.stall         = stall;
  assign bus.flush_de      = flush_de;
  assign bus.bubble_alu    = bubble_alu;
  assign bus.bubble_lsu    = bubble_lsu;
  assign bus.jump_en       = jump_en;
  assign bus.jump_addr_o   = jump_en ? bus.jump_addr : 32'd0;
  assign bus.mul_done      = mul_done;
  assign bus.discard_fetch = discard;
  assign bus.busy          = (state == MUL) | fetch_kill;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench with directed scenarios and a randomized run against a behavioural model
module tb_pipe_ctrl;
  localparam int MUL_LAT = 4;
  typedef struct packed {
    logic [3:0]  stall;
    logic        flush_de, bubble_alu, bubble_lsu, jump_en;
    logic [31:0] jump_addr_o;
    logic        mul_done, discard_fetch, busy;
  } out_t;
  typedef struct {
    string name;
    out_t  exp;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pipe_ctrl_if bus();
  pipe_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  sb_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  mul_prog = 0;
  bit  kill = 1'b0;
  function automatic out_t mk(logic [3:0] st, logic fd, logic ba, logic bl, logic je,
                              logic [31:0] ja, logic md, logic df, logic bz);
    out_t o;
    o = '{st, fd, ba, bl, je, ja, md, df, bz};
    return o;
  endfunction
  // Reference: a multiply makes MUL_LAT progress cycles; LSU waits add cycles without progress
  function automatic out_t model(bit rst, bit de, bit jr, logic [31:0] ja, bit ms, bit ifw, bit lsw);
    out_t o;
    int   prog_nx;
    bit   kill_nx;
    o = '0;
    if (rst) begin
      mul_prog = 0;
      kill = 1'b0;
    end
    prog_nx = mul_prog;
    o.busy = (mul_prog > 0) || kill;
    if (mul_prog > 0) begin
      if (lsw) o.stall = 4'hF;
      else if (mul_prog + 1 == MUL_LAT) begin
        o.mul_done = 1'b1;
        prog_nx = 0;
      end else begin
        o.stall = 4'h7;
        o.bubble_lsu = 1'b1;
        prog_nx = mul_prog + 1;
      end
    end else if (lsw) o.stall = 4'hF;
    else if (jr) begin
      o.jump_en = 1'b1;
      o.jump_addr_o = ja;
      o.flush_de = 1'b1;
      o.bubble_alu = 1'b1;
    end else if (ms) begin
      o.stall = 4'h7;
      o.bubble_lsu = 1'b1;
      prog_nx = 1;
    end else if (de) begin
      o.stall = 4'h3;
      o.bubble_alu = 1'b1;
    end else if (ifw) begin
      o.stall = 4'h1;
      o.flush_de = 1'b1;
    end
    o.discard_fetch = kill && !ifw;
    kill_nx = (o.jump_en && ifw) ? 1'b1 : (o.discard_fetch ? 1'b0 : kill);
    mul_prog = rst ? 0 : prog_nx;
    kill = rst ? 1'b0 : kill_nx;
    return o;
  endfunction
  task automatic step(bit rst, bit de, bit jr, logic [31:0] ja, bit ms, bit ifw, bit lsw,
                      string nm, bit use_model, out_t exp);
    out_t m;
    @(posedge clk);
    #1;
    rst_n = ~rst;
    bus.de_stall = de;
    bus.jump_req = jr;
    bus.jump_addr = ja;
    bus.mul_start = ms;
    bus.ifu_bus_wait = ifw;
    bus.lsu_bus_wait = lsw;
    m = model(rst, de, jr, ja, ms, ifw, lsw);
    sb.push_back('{nm, use_model ? m : exp});
  endtask
  task automatic dstep(bit rst, bit de, bit jr, logic [31:0] ja, bit ms, bit ifw, bit lsw,
                       string nm, out_t exp);
    step(rst, de, jr, ja, ms, ifw, lsw, nm, 1'b0, exp);
  endtask
  always @(negedge clk) begin
    out_t act;
    sb_t  e;
    act = '{bus.stall, bus.flush_de, bus.bubble_alu, bus.bubble_lsu, bus.jump_en,
            bus.jump_addr_o, bus.mul_done, bus.discard_fetch, bus.busy};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
      checks++;
      if (!(act.stall inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF})) begin
        failures++;
        $display("FAIL %s_stall_order actual=%b required=contiguous", e.name, act.stall);
      end
    end
  end
  initial begin
    out_t z;
    z = '0;
    bus.de_stall = 0; bus.jump_req = 0; bus.jump_addr = 0;
    bus.mul_start = 0; bus.ifu_bus_wait = 0; bus.lsu_bus_wait = 0;
    dstep(1, 0,0,0,0,0,0, "reset", z);
    dstep(0, 0,0,0,0,0,0, "idle", z);
    // plain multiply
    dstep(0, 0,0,0,1,0,0, "mul_c1", mk(4'h7,0,0,1,0,0,0,0,0));
    dstep(0, 0,0,0,1,0,0, "mul_c2", mk(4'h7,0,0,1,0,0,0,0,1));
    dstep(0, 0,0,0,1,0,0, "mul_c3", mk(4'h7,0,0,1,0,0,0,0,1));
    dstep(0, 0,0,0,1,0,0, "mul_done", mk(4'h0,0,0,0,0,0,1,0,1));
    dstep(0, 0,0,0,0,0,0, "mul_after", z);
    // multiply with LSU wait
    dstep(0, 0,0,0,1,0,0, "mlw_c1", mk(4'h7,0,0,1,0,0,0,0,0));
    dstep(0, 0,0,0,1,0,1, "mlw_c2", mk(4'hF,0,0,0,0,0,0,0,1));
    dstep(0, 0,1,32'h55,1,0,1, "mlw_c3", mk(4'hF,0,0,0,0,0,0,0,1));
    dstep(0, 1,1,32'h55,1,0,0, "mlw_c4", mk(4'h7,0,0,1,0,0,0,0,1));
    dstep(0, 0,0,0,1,0,0, "mlw_c5", mk(4'h7,0,0,1,0,0,0,0,1));
    dstep(0, 0,0,0,1,0,0, "mlw_done", mk(4'h0,0,0,0,0,0,1,0,1));
    dstep(0, 0,0,0,0,0,0, "mlw_after", z);
    // reset mid-multiply
    dstep(0, 0,0,0,1,0,0, "rmm_c1", mk(4'h7,0,0,1,0,0,0,0,0));
    dstep(0, 0,0,0,1,0,0, "rmm_c2", mk(4'h7,0,0,1,0,0,0,0,1));
    dstep(1, 0,0,0,0,0,0, "rmm_reset", z);
    dstep(0, 0,0,0,0,0,0, "rmm_release", z);
    dstep(0, 0,0,0,1,0,0, "rmm_restart", mk(4'h7,0,0,1,0,0,0,0,0));
    dstep(1, 0,0,0,0,0,0, "rmm_reset2", z);
    dstep(0, 0,0,0,0,0,0, "rmm_idle", z);
    // redirect with fetch outstanding
    dstep(0, 0,1,32'h8000_0040,0,1,0, "jmp_c0", mk(4'h0,1,1,0,1,32'h8000_0040,0,0,0));
    dstep(0, 0,0,0,0,1,0, "jmp_c1", mk(4'h1,1,0,0,0,0,0,0,1));
    dstep(0, 0,0,0,0,1,0, "jmp_c2", mk(4'h1,1,0,0,0,0,0,0,1));
    dstep(0, 0,0,0,0,0,0, "jmp_discard", mk(4'h0,0,0,0,0,0,0,1,1));
    dstep(0, 0,0,0,0,0,0, "jmp_after", z);
    // priority sweep
    dstep(0, 1,1,32'h1234,0,1,0, "pri_jmp", mk(4'h0,1,1,0,1,32'h1234,0,0,0));
    dstep(0, 1,0,0,0,1,0, "pri_de_ifu", mk(4'h3,0,1,0,0,0,0,0,1));
    dstep(0, 0,1,32'h99,0,0,1, "pri_lsu_jmp", mk(4'hF,0,0,0,0,0,0,1,1));
    dstep(0, 0,0,0,0,0,0, "pri_after", z);
    // redirect while kill pending and fetch still outstanding keeps single kill
    dstep(0, 0,1,32'hA0,0,1,0, "rk_j1", mk(4'h0,1,1,0,1,32'hA0,0,0,0));
    dstep(0, 0,1,32'hB0,0,1,0, "rk_j2", mk(4'h0,1,1,0,1,32'hB0,0,0,1));
    dstep(0, 0,1,32'hC0,0,0,0, "rk_j3", mk(4'h0,1,1,0,1,32'hC0,0,1,1));
    dstep(0, 0,0,0,0,0,0, "rk_after", z);
    // lone decode stall
    dstep(0, 1,0,0,0,0,0, "de_only", mk(4'h3,0,1,0,0,0,0,0,0));
    dstep(0, 0,0,0,0,0,0, "de_after", z);
    // randomized run against the model
    for (int i = 0; i < 600; i++)
      step(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0, $urandom,
           ($urandom % 5) == 0, ($urandom % 3) == 0, ($urandom % 6) == 0, "rand", 1'b1, z);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core: PC, IFU/DE, DE/ALU and ALU/LSU registers, plus the BIU-attached fetch and load/store units.
- Each cycle it arbitrates the stall and redirect sources: LSU bus wait, ALU jump/branch, multicycle multiply, decode load-use stall and IFU bus wait.
- From that it drives per-stage hold, bubble and flush controls.
- It owns the multiply-latency counter and discards the stale fetch that returns after a redirect taken while a fetch is outstanding.

Parameters:
- MUL_LAT, 4, total cycles a multiply occupies the ALU stage (legal range 2..16).
- CNT_W, 4, multiply counter width (must hold MUL_LAT-2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- de_stall  in  1  load-use hazard from decode
- jump_req  in  1  ALU-stage taken jump/branch (level; held while ALU is stalled)
- jump_addr  in  32  redirect target
- mul_start  in  1  ALU stage holds a MUL-class instruction (level)
- ifu_bus_wait  in  1  fetch transaction outstanding on BIU
- lsu_bus_wait  in  1  load/store transaction outstanding on BIU
- stall  out  4  hold enables: [0] PC, [1] IFU/DE, [2] DE/ALU, [3] ALU/LSU
- flush_de  out  1  load NOP into IFU/DE
- bubble_alu  out  1  load NOP into DE/ALU
- bubble_lsu  out  1  load NOP into ALU/LSU
- jump_en  out  1  redirect PC this cycle
- jump_addr_o  out  32  redirect target to PC
- mul_done  out  1  multiply result valid; ALU stage advances this cycle
- discard_fetch  out  1  drop the instruction returned by IFU this cycle
- busy  out  1  MUL state active or fetch kill pending

Behaviour:
- Registered state:
  - FSM state RUN/MUL.
  - cnt[CNT_W-1:0].
  - fetch_kill flag.
- Reset: all registers clear asynchronously on rst_n low; state=RUN, cnt=0, fetch_kill=0.
- Output defaults: all outputs are combinational from state and inputs. Default values are 0, and jump_addr_o=0 unless jump_en=1. With state=RUN and all inputs 0, every output is 0.
- RUN priority, highest first:
  - P1 lsu_bus_wait=1: stall=4'b1111. All other requests are ignored; they persist because the stages are held.
  - P2 jump_req=1: jump_en=1, jump_addr_o=jump_addr, flush_de=1, bubble_alu=1, stall=0. If ifu_bus_wait=1, set fetch_kill. de_stall and mul_start are ignored, since the younger instructions are killed.
  - P3 mul_start=1: stall=4'b0111, bubble_lsu=1, cnt<=MUL_LAT-2, next state=MUL.
  - P4 de_stall=1: stall=4'b0011, bubble_alu=1.
  - P5 ifu_bus_wait=1: stall=4'b0001, flush_de=1.
- MUL state:
  - lsu_bus_wait=1: stall=4'b1111, cnt frozen, mul_done=0.
  - Otherwise, cnt!=0: stall=4'b0111, bubble_lsu=1, cnt<=cnt-1.
  - Otherwise, cnt==0: mul_done=1, stall=0, next state=RUN. The instruction advances, so mul_start falls next cycle.
  - jump_req and de_stall are ignored in MUL (ALU is occupied).
- Multiply latency: the mul_start cycle through the mul_done cycle totals exactly MUL_LAT cycles when no LSU wait occurs.
- fetch_kill:
  - discard_fetch = fetch_kill & ~ifu_bus_wait.
  - fetch_kill clears on the cycle discard_fetch=1.
  - If a new jump is taken while fetch_kill=1 and ifu_bus_wait=1, fetch_kill stays 1 (only one fetch is outstanding).
  - If jump_en and discard_fetch occur in the same cycle with ifu_bus_wait=0, fetch_kill clears.
- busy = (state==MUL) | fetch_kill.
- Reset mid-multiply abandons the operation; the first cycle after reset release is RUN with cnt=0.
- No output ever has stall[k]=1 while stall[j]=0 for any j<k.

Test Plan:
1. Reset mid-MUL: assert rst_n=0 during MUL cnt=1 → outputs 0 immediately, state RUN, busy=0 after release.
2. mul_start=1 with MUL_LAT=4, no waits → stall=0111 and bubble_lsu=1 for 3 cycles, then mul_done=1 with stall=0000 on cycle 4; busy high for cycles 2-4.
3. Multiply with lsu_bus_wait=1 for 2 cycles starting at the second MUL cycle → stall=1111 for those cycles, cnt frozen, mul_done arrives 2 cycles late (cycle 6).
4. jump_req=1, jump_addr=0x8000_0040, ifu_bus_wait=1 for 3 cycles → jump_en=1, jump_addr_o=0x8000_0040, flush_de=1, bubble_alu=1 in cycle 0; discard_fetch=1 exactly in cycle 3, then busy=0.
5. Priority sweep: jump_req+de_stall+ifu_bus_wait together → only the jump actions apply (stall=0000); de_stall+ifu_bus_wait → stall=0011, bubble_alu=1, flush_de=0; lsu_bus_wait+jump_req → stall=1111, jump_en=0.
6. de_stall=1 alone for 1 cycle → stall=0011 and bubble_alu=1 for that cycle; next cycle all outputs 0.
